aie_trip_collector: RTL and testbench
=====================================

// Module: aie_trip_collector
// PURPOSE
//  Receiving end of the per-ID sweep driven by aie_addr_gen. Samples the one-shot per-ID result
//  strobe during each sweep, dedupes and records per-ID trip flags, captures the first faulting
//  ID/value, and publishes a stable snapshot plus a sticky interlock at sweep end.
//  Sits between the per-ID envelope calculation and the interlock output/status register block.
// PARAMETERS
//  MAX_ID_NUM     60    IDs per sweep; aie_addr >= MAX_ID_NUM marks sweep end
//  SWEEP_TIMEOUT  4095  enabled clocks allowed in COLLECT before forced publish with error
//  DATA_W         16    width of signed per-ID result value
// PORTS
//  clk           in   1       system clock
//  reset_n       in   1       asynchronous reset, active-low
//  clk_enable    in   1       global enable; 0 freezes all state except clear handling
//  trig          in   1       sweep start, same pulse that restarts aie_addr_gen
//  aie_addr      in   7       current ID from address generator
//  wr_one        in   1       per-ID result strobe (may be high >1 clk per ID)
//  mask          in   1       1 = current ID enabled for interlock
//  trip_in       in   1       1 = current ID result outside envelope
//  data_in       in   DATA_W  signed result value for current ID
//  clear         in   1       operator clear of sticky interlock
//  trip_vec      out  64      per-ID trips of last published sweep, bits >= MAX_ID_NUM zero
//  trip_any      out  1       OR of trip_vec
//  first_id      out  7       first tripping ID of last published sweep, 7'h7F if none
//  first_data    out  DATA_W  data_in captured with first_id, 0 if none
//  sweep_done    out  1       one-clock pulse in PUBLISH
//  sweep_err     out  1       last published sweep incomplete (missing ID or timeout)
//  interlock_out out  1       sticky interlock request
//  busy          out  1       1 while in COLLECT
//  sweep_cnt     out  16      published sweep counter, wraps 16'hFFFF -> 0
// BEHAVIOUR
//  Reset: all outputs 0 except first_id = 7'h7F; state IDLE; working registers cleared.
//  States: IDLE, COLLECT, PUBLISH. Transitions only on cycles with clk_enable = 1.
//  trig = 1 in any state -> COLLECT next clk; clears seen_vec, work_trip, work_first, timer.
//    trig in COLLECT aborts the sweep silently (no publish, outputs hold previous snapshot).
//    trig wins over sweep-end and timeout in the same cycle.
//  COLLECT, accept when wr_one = 1, aie_addr < MAX_ID_NUM and seen_vec[aie_addr] = 0:
//    set seen_vec[aie_addr]; if mask & trip_in set work_trip[aie_addr]; if first not yet
//    captured this sweep, capture aie_addr/data_in into work_first. Repeat strobes ignored.
//  Sweep end: aie_addr >= MAX_ID_NUM in COLLECT -> PUBLISH next clk. Timer counts enabled clks
//    in COLLECT; timer == SWEEP_TIMEOUT -> PUBLISH with timeout flag.
//  PUBLISH (1 clk): trip_vec <= work_trip; trip_any; first_id/first_data <= work_first (or
//    7'h7F/0); sweep_err <= timeout | ~&seen_vec[MAX_ID_NUM-1:0]; sweep_done = 1;
//    sweep_cnt++; -> IDLE. Outputs registered; stable until next PUBLISH.
//  Latency: last accepted ID -> outputs valid 2 clk after aie_addr reaches MAX_ID_NUM.
//  interlock_out: set in PUBLISH if trip_any_next | sweep_err_next; cleared by clear = 1 in
//    any other cycle; set dominates clear in same cycle. clear acts even when clk_enable = 0.
//  clk_enable = 0: no accept, no timer advance, no state change; wr_one ignored.
//  reset_n low mid-sweep: immediate return to reset values; no partial publish.
// TESTING
//  1) Reset, trig, IDs 0..59 strobed, no trips, addr -> 60 -> sweep_done, trip_any=0,
//     first_id=7'h7F, sweep_err=0, sweep_cnt=1, interlock_out=0.
//  2) Trips on IDs 12 (data -300) and 40, mask=1 -> trip_vec bits 12,40 set, first_id=12,
//     first_data=-300, interlock_out=1; clear -> 0; next clean sweep keeps 0.
//  3) ID 25 trip_in=1 mask=0, wr_one held 3 clks per ID -> trip_vec=0, no duplicate effects.
//  4) ID 33 never strobed -> sweep_err=1, interlock_out=1; addr stuck at 20 -> publish after
//     4095 enabled clks with sweep_err=1.
//  5) trig at ID 30 with prior trip on ID 5 -> no sweep_done; restarted clean sweep publishes
//     trip_vec=0; clear and publish same cycle with trip -> interlock_out stays 1.
//  6) reset_n low at ID 50, clk_enable toggling 50% during sweep -> reset values at once; gaps
//     only stretch timing, results match test 1.

Source files
------------

// File: rtl/aie_trip_if.sv
// Sweep-side bus between the per-ID envelope stage and the trip collector.
// master: drives sweep stimulus and consumes the published snapshot.
// slave:  the collector itself.
interface aie_trip_if #(
  parameter int unsigned DATA_W = 16
) ();

  // Sweep inputs to the collector
  logic              trig;
  logic [6:0]        aie_addr;
  logic              wr_one;
  logic              mask;
  logic              trip_in;
  logic [DATA_W-1:0] data_in;
  logic              clear;

  // Published snapshot and status
  logic [63:0]       trip_vec;
  logic              trip_any;
  logic [6:0]        first_id;
  logic [DATA_W-1:0] first_data;
  logic              sweep_done;
  logic              sweep_err;
  logic              interlock_out;
  logic              busy;
  logic [15:0]       sweep_cnt;

  modport master (
    output trig, aie_addr, wr_one, mask, trip_in, data_in, clear,
    input  trip_vec, trip_any, first_id, first_data, sweep_done, sweep_err,
           interlock_out, busy, sweep_cnt
  );

  modport slave (
    input  trig, aie_addr, wr_one, mask, trip_in, data_in, clear,
    output trip_vec, trip_any, first_id, first_data, sweep_done, sweep_err,
           interlock_out, busy, sweep_cnt
  );

endinterface

// File: rtl/aie_trip_collector.sv
// Collects per-ID trip results during an address sweep, dedupes repeated strobes,
// remembers the first tripping ID/value and publishes a stable snapshot plus a
// sticky interlock request when the sweep ends (or times out).
module aie_trip_collector #(
  parameter int unsigned MAX_ID_NUM    = 60,
  parameter int unsigned SWEEP_TIMEOUT = 4095,
  parameter int unsigned DATA_W        = 16
) (
  input logic       clk,
  input logic       reset_n,
  input logic       clk_enable,
  aie_trip_if.slave bus
);

  localparam int unsigned TimerW = (SWEEP_TIMEOUT > 1) ? $clog2(SWEEP_TIMEOUT + 1) : 1;
  localparam logic [TimerW-1:0] TimeoutVal = TimerW'(SWEEP_TIMEOUT);
  localparam logic [6:0] EndAddr = 7'(MAX_ID_NUM);
  localparam logic [6:0] NoId    = 7'h7F;
  // Bits of the 64-bit vectors that correspond to real IDs
  localparam logic [63:0] IdMask = (MAX_ID_NUM >= 64) ? {64{1'b1}} :
                                   ((64'd1 << MAX_ID_NUM) - 64'd1);

  typedef enum logic [1:0] {StIdle, StCollect, StPublish} state_e;

  state_e            state_q;

  // Working registers for the sweep in progress
  logic [63:0]       seen_q;
  logic [63:0]       work_trip_q;
  logic              work_first_vld_q;
  logic [6:0]        work_first_id_q;
  logic [DATA_W-1:0] work_first_data_q;
  logic [TimerW-1:0] timer_q;
  logic              timeout_q;

  // Published snapshot
  logic [63:0]       trip_vec_q;
  logic              trip_any_q;
  logic [6:0]        first_id_q;
  logic [DATA_W-1:0] first_data_q;
  logic              sweep_done_q;
  logic              sweep_err_q;
  logic              interlock_q;
  logic [15:0]       sweep_cnt_q;

  logic              in_range;
  logic              accept;
  logic              hit;
  logic              timer_hit;
  logic              trip_any_nxt;
  logic              sweep_err_nxt;
  logic              publish;
  logic [5:0]        id_idx;

  // Decode of the current strobe and of the snapshot that PUBLISH would write
  always_comb begin
    id_idx        = bus.aie_addr[5:0];
    in_range      = bus.aie_addr < EndAddr;
    hit           = bus.mask & bus.trip_in;
    accept        = (state_q == StCollect) && clk_enable && !bus.trig && bus.wr_one &&
                    in_range && !seen_q[id_idx];
    timer_hit     = timer_q == TimeoutVal;
    trip_any_nxt  = |(work_trip_q & IdMask);
    sweep_err_nxt = timeout_q | ((seen_q & IdMask) != IdMask);
    publish       = (state_q == StPublish) && clk_enable && !bus.trig;
  end

  // Sweep FSM, working registers and registered snapshot outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q           <= StIdle;
      seen_q            <= '0;
      work_trip_q       <= '0;
      work_first_vld_q  <= 1'b0;
      work_first_id_q   <= NoId;
      work_first_data_q <= '0;
      timer_q           <= '0;
      timeout_q         <= 1'b0;
      trip_vec_q        <= '0;
      trip_any_q        <= 1'b0;
      first_id_q        <= NoId;
      first_data_q      <= '0;
      sweep_done_q      <= 1'b0;
      sweep_err_q       <= 1'b0;
      sweep_cnt_q       <= '0;
    end else begin
      // sweep_done is a pulse; it never stretches while clk_enable is low
      sweep_done_q <= 1'b0;
      if (clk_enable) begin
        if (bus.trig) begin
          // Restart wins over sweep end / timeout; an open sweep is dropped silently
          state_q           <= StCollect;
          seen_q            <= '0;
          work_trip_q       <= '0;
          work_first_vld_q  <= 1'b0;
          work_first_id_q   <= NoId;
          work_first_data_q <= '0;
          timer_q           <= '0;
          timeout_q         <= 1'b0;
        end else begin
          case (state_q)
            StIdle: ;
            StCollect: begin
              if (accept) begin
                seen_q[id_idx] <= 1'b1;
                if (hit) begin
                  work_trip_q[id_idx] <= 1'b1;
                  if (!work_first_vld_q) begin
                    work_first_vld_q  <= 1'b1;
                    work_first_id_q   <= bus.aie_addr;
                    work_first_data_q <= bus.data_in;
                  end
                end
              end
              if (!in_range) begin
                state_q <= StPublish;
              end else if (timer_hit) begin
                state_q   <= StPublish;
                timeout_q <= 1'b1;
              end else begin
                timer_q <= timer_q + 1'b1;
              end
            end
            StPublish: begin
              trip_vec_q   <= work_trip_q & IdMask;
              trip_any_q   <= trip_any_nxt;
              first_id_q   <= work_first_vld_q ? work_first_id_q : NoId;
              first_data_q <= work_first_vld_q ? work_first_data_q : '0;
              sweep_err_q  <= sweep_err_nxt;
              sweep_done_q <= 1'b1;
              sweep_cnt_q  <= sweep_cnt_q + 16'd1;
              state_q      <= StIdle;
            end
            default: state_q <= StIdle;
          endcase
        end
      end
    end
  end

  // Sticky interlock: publish-time set dominates clear; clear works with clk_enable low
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      interlock_q <= 1'b0;
    end else if (publish && (trip_any_nxt || sweep_err_nxt)) begin
      interlock_q <= 1'b1;
    end else if (bus.clear) begin
      interlock_q <= 1'b0;
    end
  end

  assign bus.trip_vec      = trip_vec_q;
  assign bus.trip_any      = trip_any_q;
  assign bus.first_id      = first_id_q;
  assign bus.first_data    = first_data_q;
  assign bus.sweep_done    = sweep_done_q;
  assign bus.sweep_err     = sweep_err_q;
  assign bus.interlock_out = interlock_q;
  assign bus.busy          = (state_q == StCollect);
  assign bus.sweep_cnt     = sweep_cnt_q;

endmodule

// File: tb/tb_aie_trip_collector.sv
// Directed sweeps against aie_trip_collector; expected snapshots are queued by the
// stimulus and checked by a monitor whenever sweep_done pulses.
module tb_aie_trip_collector;

  typedef struct {
    logic [63:0] tv;
    logic [6:0]  fid;
    logic [15:0] fdata;
    logic        err;
    logic        il;
    logic [15:0] cnt;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic clk_en = 1'b0;

  aie_trip_if #(.DATA_W(16)) bus ();

  aie_trip_collector #(
    .MAX_ID_NUM   (60),
    .SWEEP_TIMEOUT(4095),
    .DATA_W       (16)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .clk_enable(clk_en),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  int          tests = 0;
  int          fails = 0;
  logic [15:0] cnt_exp = '0;
  bit          il_exp = 1'b0;
  exp_t        sb[$];
  exp_t        mon_e;

  bit          id_mask[64];
  bit          id_trip[64];
  bit          id_skip[64];
  logic [15:0] id_data[64];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every sweep_done must match the oldest queued expectation
  always @(negedge clk) begin
    if (reset_n && bus.sweep_done === 1'b1) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_sweep_done: got sweep_cnt %0d, expected no publish",
                 bus.sweep_cnt);
      end else begin
        mon_e = sb.pop_front();
        check("trip_vec", bus.trip_vec, mon_e.tv);
        check("trip_any", 64'(bus.trip_any), 64'(mon_e.tv != 64'd0));
        check("first_id", 64'(bus.first_id), 64'(mon_e.fid));
        check("first_data", 64'(bus.first_data), 64'(mon_e.fdata));
        check("sweep_err", 64'(bus.sweep_err), 64'(mon_e.err));
        check("interlock_pub", 64'(bus.interlock_out), 64'(mon_e.il));
        check("sweep_cnt", 64'(bus.sweep_cnt), 64'(mon_e.cnt));
      end
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: got no finish, expected finish before 1ms");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_arrays();
    for (int i = 0; i < 64; i++) begin
      id_mask[i] = 1'b1;
      id_trip[i] = 1'b0;
      id_skip[i] = 1'b0;
      id_data[i] = 16'(i * 3);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_trip_vec"}, bus.trip_vec, 64'd0);
    check({tag, "_first_id"}, 64'(bus.first_id), 64'h7F);
    check({tag, "_first_data"}, 64'(bus.first_data), 64'd0);
    check({tag, "_interlock"}, 64'(bus.interlock_out), 64'd0);
    check({tag, "_busy"}, 64'(bus.busy), 64'd0);
    check({tag, "_sweep_cnt"}, 64'(bus.sweep_cnt), 64'd0);
    check({tag, "_sweep_err"}, 64'(bus.sweep_err), 64'd0);
  endtask

  task automatic wait_done(input int bound);
    int n = 0;
    while (sb.size() != 0 && n < bound) begin
      tick();
      n++;
    end
    if (sb.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL sweep_done_timeout: got no sweep_done in %0d clks, expected one", bound);
      sb.delete();
    end
  endtask

  task automatic pulse_clear(input bit en);
    clk_en    = en;
    bus.clear = 1'b1;
    tick();
    bus.clear = 1'b0;
    clk_en    = 1'b1;
    il_exp    = 1'b0;
  endtask

  // One sweep: IDs 0..stop_id-1, each strobed for `hold` enabled clocks.
  // do_end drives aie_addr=60; timeout_mode parks aie_addr at 20 instead.
  task automatic sweep(input int hold, input bit toggle, input int stop_id, input bit do_end,
                       input bit clear_pub, input bit timeout_mode);
    exp_t e;
    bit   en_ph;
    int   k;
    en_ph       = 1'b0;
    clk_en      = 1'b1;
    bus.trig    = 1'b1;
    tick();
    bus.trig    = 1'b0;
    for (int id = 0; id < stop_id; id++) begin
      bus.aie_addr = 7'(id);
      bus.mask     = id_mask[id];
      bus.trip_in  = id_trip[id];
      bus.wr_one   = !id_skip[id];
      k = 0;
      while (k < hold) begin
        en_ph       = toggle ? ~en_ph : 1'b1;
        clk_en      = en_ph;
        bus.data_in = id_data[id] + 16'(k);
        tick();
        if (en_ph) k++;
      end
    end
    bus.wr_one  = 1'b0;
    bus.trip_in = 1'b0;
    clk_en      = 1'b1;
    if (!(do_end || timeout_mode)) return;
    e.tv    = '0;
    e.fid   = 7'h7F;
    e.fdata = '0;
    e.err   = timeout_mode;
    for (int i = 0; i < 60; i++) begin
      if (i < stop_id && !id_skip[i]) begin
        if (id_mask[i] && id_trip[i]) begin
          e.tv[i] = 1'b1;
          if (e.fid == 7'h7F) begin
            e.fid   = 7'(i);
            e.fdata = id_data[i];
          end
        end
      end else begin
        e.err = 1'b1;
      end
    end
    e.il    = (e.tv != 64'd0 || e.err) ? 1'b1 : il_exp;
    il_exp  = e.il;
    cnt_exp = cnt_exp + 16'd1;
    e.cnt   = cnt_exp;
    sb.push_back(e);
    if (timeout_mode) begin
      bus.aie_addr = 7'd20;
      wait_done(5000);
      return;
    end
    bus.aie_addr = 7'd60;
    tick();
    // This cycle is PUBLISH
    bus.aie_addr = 7'd0;
    if (clear_pub) bus.clear = 1'b1;
    tick();
    bus.clear = 1'b0;
    wait_done(20);
  endtask

  initial begin
    bus.trig     = 1'b0;
    bus.aie_addr = '0;
    bus.wr_one   = 1'b0;
    bus.mask     = 1'b0;
    bus.trip_in  = 1'b0;
    bus.data_in  = '0;
    bus.clear    = 1'b0;
    clear_arrays();
    repeat (3) tick();
    check_reset_values("reset");
    check("reset_sweep_done", 64'(bus.sweep_done), 64'd0);
    reset_n = 1'b1;
    tick();

    // 1) clean sweep
    clk_en   = 1'b1;
    bus.trig = 1'b1;
    tick();
    bus.trig = 1'b0;
    check("busy_after_trig", 64'(bus.busy), 64'd1);
    sweep(1, 1'b0, 60, 1'b1, 1'b0, 1'b0);
    check("busy_after_publish", 64'(bus.busy), 64'd0);

    // 2) trips on 12 and 40, then clear with clk_enable low, then clean sweep
    id_trip[12] = 1'b1;
    id_data[12] = 16'(-300);
    id_trip[40] = 1'b1;
    sweep(1, 1'b0, 60, 1'b1, 1'b0, 1'b0);
    pulse_clear(1'b0);
    check("clear_while_disabled", 64'(bus.interlock_out), 64'd0);
    clear_arrays();
    sweep(1, 1'b0, 60, 1'b1, 1'b0, 1'b0);

    // 3) masked trip with repeated strobes; then a real trip with changing data on repeats
    id_trip[25] = 1'b1;
    id_mask[25] = 1'b0;
    sweep(3, 1'b0, 60, 1'b1, 1'b0, 1'b0);
    id_trip[26] = 1'b1;
    id_data[26] = 16'd100;
    id_trip[27] = 1'b1;
    sweep(3, 1'b0, 60, 1'b1, 1'b0, 1'b0);
    pulse_clear(1'b1);
    clear_arrays();

    // 4) missing ID 33, then a sweep stuck at ID 20 until timeout
    id_skip[33] = 1'b1;
    sweep(1, 1'b0, 60, 1'b1, 1'b0, 1'b0);
    clear_arrays();
    sweep(1, 1'b0, 21, 1'b0, 1'b0, 1'b1);
    pulse_clear(1'b1);
    check("clear_after_timeout", 64'(bus.interlock_out), 64'd0);

    // 5) abort at ID 30 with trip on 5, clean restart, then clear during a tripping publish
    id_trip[5] = 1'b1;
    sweep(1, 1'b0, 30, 1'b0, 1'b0, 1'b0);
    clear_arrays();
    sweep(1, 1'b0, 60, 1'b1, 1'b0, 1'b0);
    id_trip[7] = 1'b1;
    id_data[7] = 16'h1234;
    sweep(1, 1'b0, 60, 1'b1, 1'b1, 1'b0);
    check("set_beats_clear", 64'(bus.interlock_out), 64'd1);
    pulse_clear(1'b1);
    check("clear_idle", 64'(bus.interlock_out), 64'd0);
    clear_arrays();

    // 6) reset mid-sweep, then a clean sweep with clk_enable toggling
    sweep(1, 1'b1, 50, 1'b0, 1'b0, 1'b0);
    reset_n = 1'b0;
    #2;
    check_reset_values("midreset");
    cnt_exp = '0;
    il_exp  = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();
    sweep(1, 1'b1, 60, 1'b1, 1'b0, 1'b0);
    repeat (5) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
